// File: rtl/multi_clock_gen.sv
// Per-channel programmable clock divider with glitch-free, period-aligned limit updates.
// Optional MULTI_CLOCK_GEN_PHASE_SYNC_EN: sync pulse realigns all enabled channels to phase 0.
module multi_clock_gen #(
  parameter int CLK_IN_HZ    = 100000000,
  parameter int CHANNELS     = 4,
  parameter int DIV_WIDTH    = 24,
  parameter int DEFAULT_FREQ = 60
) (
  input  logic                                            clk_in,
  input  logic                                            reset,
  input  logic [CHANNELS-1:0]                             en,
  input  logic                                            cfg_valid,
  output logic                                            cfg_ready,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [DIV_WIDTH-1:0]                            cfg_half,
  input  logic                                            sync,
  output logic [CHANNELS-1:0]                             clk_out,
  output logic [CHANNELS-1:0]                             tick
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam longint DEF_LIM_I =
    longint'(CLK_IN_HZ) / (longint'(2) * longint'(DEFAULT_FREQ)) - 1;
  localparam logic [DIV_WIDTH-1:0] DEF_LIM = DIV_WIDTH'(DEF_LIM_I);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("multi_clock_gen: CHANNELS must be in 1..16");
  end
  if (DEF_LIM_I < 0 || DEF_LIM_I > (longint'(1) << DIV_WIDTH) - 1) begin : g_bad_default
    $error("multi_clock_gen: default half-period limit does not fit DIV_WIDTH");
  end

  logic [DIV_WIDTH-1:0] act_lim  [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt      [CHANNELS];
  logic [DIV_WIDTH-1:0] pend_lim [CHANNELS];
  logic [CHANNELS-1:0]  pend;
  logic [CHANNELS-1:0]  xfer;
  logic                 sync_hit;

`ifdef MULTI_CLOCK_GEN_PHASE_SYNC_EN
  assign sync_hit = sync;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign sync_hit    = 1'b0;
`endif

  // Decoding by loop leaves out-of-range channel numbers with cfg_ready low.
  always_comb begin
    cfg_ready = 1'b0;
    xfer      = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CW'(i)) begin
        cfg_ready = ~pend[i];
        xfer[i]   = cfg_valid & ~pend[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        act_lim[i]  <= DEF_LIM;
        cnt[i]      <= '0;
        pend_lim[i] <= '0;
      end
      pend    <= '0;
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        tick[i] <= 1'b0;
        if (!en[i] || sync_hit) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          if (pend[i]) begin
            act_lim[i] <= pend_lim[i];
            pend[i]    <= 1'b0;
          end
        end else if (cnt[i] == act_lim[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= ~clk_out[i];
          tick[i]    <= ~clk_out[i];
          // Falling edge closes a full period: the only point a new limit may take over.
          if (clk_out[i] && pend[i]) begin
            act_lim[i] <= pend_lim[i];
            pend[i]    <= 1'b0;
          end
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (xfer[i]) begin
          pend_lim[i] <= cfg_half;
          pend[i]     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Randomized self-checking bench for multi_clock_gen against a period-position reference model.
module tb_multi_clock_gen;
  localparam int CLK_HZ = 100;
  localparam int DEF_F  = 10;
  localparam int CH     = 2;
  localparam int DW     = 8;
  localparam int DEF_L  = CLK_HZ / (2 * DEF_F) - 1;

  logic          clk_in = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] en = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [0:0]    cfg_chan = '0;
  logic [DW-1:0] cfg_half = '0;
  logic          sync = 1'b0;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  multi_clock_gen #(
    .CLK_IN_HZ   (CLK_HZ),
    .CHANNELS    (CH),
    .DIV_WIDTH   (DW),
    .DEFAULT_FREQ(DEF_F)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_half (cfg_half),
    .sync     (sync),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Model: each channel is a position within its current full period of 2*(L+1) cycles.
  int pos [CH];
  int lim [CH];
  int pl  [CH];
  bit pf  [CH];
  bit mout[CH];
  bit mtick[CH];
  int cyc = 0;
  int last_rise[CH];
  int intv[CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      pos[i] = 0; lim[i] = DEF_L; pl[i] = 0; pf[i] = 1'b0;
      mout[i] = 1'b0; mtick[i] = 1'b0; last_rise[i] = cyc; intv[i] = 0;
    end
  endtask

  function automatic bit model_ready();
    int c;
    c = int'(cfg_chan);
    return (c < CH) && !pf[c];
  endfunction

  task automatic model_edge();
    int c;
    bit xf;
    bit sy;
    c  = int'(cfg_chan);
    xf = cfg_valid && (c < CH) && !pf[c];
    sy = 1'b0;
`ifdef MULTI_CLOCK_GEN_PHASE_SYNC_EN
    sy = sync;
`endif
    for (int i = 0; i < CH; i++) begin
      mtick[i] = 1'b0;
      if (!en[i] || sy) begin
        pos[i] = 0; mout[i] = 1'b0;
        if (pf[i]) begin lim[i] = pl[i]; pf[i] = 1'b0; end
      end else begin
        pos[i]++;
        if (pos[i] == lim[i] + 1) begin
          mout[i] = 1'b1; mtick[i] = 1'b1;
          intv[i] = cyc - last_rise[i];
          last_rise[i] = cyc;
        end
        if (pos[i] == 2 * (lim[i] + 1)) begin
          mout[i] = 1'b0; pos[i] = 0;
          if (pf[i]) begin lim[i] = pl[i]; pf[i] = 1'b0; end
        end
      end
    end
    if (xf) begin pl[c] = int'(cfg_half); pf[c] = 1'b1; end
  endtask

  // Inputs are set at the falling edge; outputs are compared at the next falling edge.
  task automatic step();
    #1;
    check("cfg_ready", cfg_ready, model_ready());
    @(posedge clk_in);
    cyc++;
    model_edge();
    @(negedge clk_in);
    for (int i = 0; i < CH; i++) begin
      check($sformatf("clk_out[%0d]", i), clk_out[i], mout[i]);
      check($sformatf("tick[%0d]", i), tick[i], mtick[i]);
    end
  endtask

  task automatic cfg(input int c, input int h);
    cfg_chan  = c[0:0];
    cfg_half  = h[DW-1:0];
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int en_cyc;
    int hi;
    int sc;

    model_reset();
    repeat (3) @(negedge clk_in);
    check("reset_clk_out", clk_out, 0);
    check("reset_tick", tick, 0);
    check("reset_cfg_ready", cfg_ready, 1);

    reset = 1'b1;
    en = 2'b11;
    en_cyc = cyc;
    repeat (5) step();
    check("first_rise_default", last_rise[0] - en_cyc, 5);
    repeat (25) step();
    check("period_ch0_default", intv[0], 10);
    check("period_ch1_default", intv[1], 10);
    hi = 0;
    repeat (10) begin step(); hi += int'(mout[0]); end
    check("high_cycles_default", hi, 5);

    // Request a new limit in the middle of a high phase
    for (int k = 0; k < 20 && !mout[0]; k++) step();
    check("wait_high_ch0", mout[0], 1);
    cfg_chan = 1'b0; cfg_half = 8'd1;
    #1 check("ready_ch0_free", cfg_ready, 1);
    cfg(0, 1);
    cfg_chan = 1'b0; cfg_half = 8'd3;
    #1 check("ready_ch0_pending", cfg_ready, 0);
    cfg(0, 3);
    cfg_chan = 1'b1; cfg_half = 8'd0;
    #1 check("ready_ch1_indep", cfg_ready, 1);
    cfg(1, 0);
    repeat (40) step();
    check("period_ch0_l1", intv[0], 4);
    check("period_ch1_l0", intv[1], 2);

    cfg(1, 255);
    repeat (1100) step();
    check("period_ch1_lmax", intv[1], 512);

    en[0] = 1'b0;
    repeat (7) begin step(); check("clk_out0_disabled", clk_out[0], 0); end
    en[0] = 1'b1;
    en_cyc = cyc;
    repeat (2) step();
    check("first_rise_after_en", last_rise[0] - en_cyc, 2);

    repeat (400) begin
      en        = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_chan  = 1'($urandom);
      cfg_half  = 8'($urandom_range(0, 6));
      sync      = ($urandom_range(0, 15) == 0);
      step();
    end
    cfg_valid = 1'b0; sync = 1'b0; en = 2'b11;

    // Asynchronous reset in the middle of a high phase with a pending request
    cfg(1, 3);
    for (int k = 0; k < 30 && !mout[0]; k++) step();
    check("wait_high_before_reset", mout[0], 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_clk_out", clk_out, 0);
    check("async_reset_tick", tick, 0);
    model_reset();
    @(negedge clk_in);
    reset = 1'b1;
    cfg_chan = 1'b1;
    #1 check("ready_after_reset", cfg_ready, 1);
    repeat (20) step();

    cfg(0, 4);
    cfg(1, 2);
    repeat (40) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    sc = cyc;
    repeat (6) step();
`ifdef MULTI_CLOCK_GEN_PHASE_SYNC_EN
    check("sync_rise_ch0", last_rise[0] - sc, 5);
    check("sync_rise_ch1", last_rise[1] - sc, 3);
`endif
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
